// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler: FSM state encoding
// and the helper that sizes the mux select from the requester count.
package mux_sched_pkg;

  // Scheduler state: IDLE waits for any request, GRANT owns the mux select.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Width of a select able to address n inputs; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first unmasked request starting
// at ptr and wrapping around. Rotates the request vector so ptr lands on bit 0,
// priority-encodes the lowest set bit, then rotates the index back.
module rr_pick
  import mux_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]            req,
  input  logic [sel_width(N_REQ)-1:0] ptr,
  input  logic [N_REQ-1:0]            mask,
  output logic [sel_width(N_REQ)-1:0] winner,
  output logic                        found
);

  localparam int SEL_W = sel_width(N_REQ);
  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N_REQ);
  localparam logic [SEL_W:0] LAST  = (SEL_W+1)'(N_REQ - 1);

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] rotated;
  logic [SEL_W:0]   first_off;

  // Modular add of two indices below N_REQ; the wrap is an explicit compare so
  // a non-power-of-two N_REQ never produces an index past the last input.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input logic [SEL_W:0]   off);
    logic [SEL_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum > LAST) sum = sum - N_EXT;
    return sum[SEL_W-1:0];
  endfunction

  assign masked = req & ~mask;
  assign found  = |masked;

  // Rotate the masked requests so that position ptr becomes bit 0.
  always_comb begin
    rotated = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rotated[k] = masked[wrap_add(ptr, (SEL_W+1)'(k))];
    end
  end

  // Lowest set bit of the rotated vector is the nearest requester after ptr.
  always_comb begin
    first_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) first_off = (SEL_W+1)'(k);
    end
    winner = wrap_add(ptr, first_off);
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler owning the select of an N_REQ:1 data mux. Grants one
// requester at a time for at most MAX_BURST transfer beats, forwards the
// selected word over a valid/ready channel and rotates priority on release.
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_W-1:0]     data,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [sel_width(N_REQ)-1:0] sel,
  output logic [N_REQ-1:0]            ack,
  output logic                        busy
);

  localparam int SEL_W = sel_width(N_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(MAX_BURST - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_REQ - 1);

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [BC_W-1:0]   beat_cnt;

  logic              granted;
  logic              xfer;
  logic              rel_abort;
  logic              rel_burst;
  logic              release_now;
  logic [SEL_W-1:0]  next_ptr;
  logic [SEL_W-1:0]  pick_ptr;
  logic [SEL_W-1:0]  winner;
  logic [N_REQ-1:0]  pick_mask;
  logic [N_REQ-1:0]  sel_onehot;
  logic              found;

  assign granted    = (state == ST_GRANT);
  assign busy       = granted;
  assign sel_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << sel;

  // The granted requester's own req is its valid; a transfer is valid & ready.
  assign out_valid = granted & req[sel];
  assign xfer      = out_valid & out_ready;
  assign ack       = xfer ? sel_onehot : '0;

  // A grant ends when the owner withdraws, or on the last beat of a full burst.
  assign rel_abort   = granted & ~req[sel];
  assign rel_burst   = xfer & (beat_cnt == BC_LAST);
  assign release_now = rel_abort | rel_burst;

  // Priority moves to the requester after the one just released.
  assign next_ptr = (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);

  // In GRANT the picker already looks at the post-release pointer, so a new
  // winner is loaded on the release edge without an idle bubble. Only an
  // aborting owner is masked; a burst-limited owner may win again if alone.
  assign pick_ptr  = granted ? next_ptr : ptr;
  assign pick_mask = rel_abort ? sel_onehot : '0;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .mask   (pick_mask),
    .winner (winner),
    .found  (found)
  );

  // Data mux driven by the registered select; compare-based so unused select
  // codes for a non-power-of-two N_REQ simply yield zero.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel == SEL_W'(k)) out_data = data[k*DATA_W +: DATA_W];
    end
  end

  // Scheduler FSM: grant, burst counting, release and same-cycle re-arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            sel      <= winner;
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            ptr      <= next_ptr;
            beat_cnt <= '0;
            if (found) sel <= winner;
            else       state <= ST_IDLE;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + BC_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
